// File: rtl/dmem_loader_if.sv
// dmem_loader_if: byte-stream handshake and external data-memory write port
interface dmem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  modport master (
    input  in_valid, in_data,
    output in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );
  modport slave (
    output in_valid, in_data,
    input  in_ready, Ext_MemWrite, Ext_WriteData, Ext_DataAdr
  );
endinterface

// File: rtl/dmem_loader.sv
// dmem_loader: packs a byte stream into words, writes them to CPU data memory, then releases CPU reset
module dmem_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          WORD_COUNT    = 64,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  dmem_loader_if.master bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic [15:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, HOLD, RUN} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] part_q, part_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] adr_q, adr_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  cnt_q, cnt_d;
  // next-state logic: byte packing, write issue, release countdown
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    part_d  = part_q;
    wdata_d = wdata_q;
    adr_d   = adr_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RUN: if (start) begin
        state_d = COLLECT;
        idx_d   = '0;
        words_d = '0;
      end
      COLLECT: if (bus.in_valid) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = WRITE;
          wdata_d = {bus.in_data, part_q};
          adr_d   = BASE_ADDR + {14'b0, words_q, 2'b0};
        end else part_d[{idx_q, 3'b0} +: 8] = bus.in_data;
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        cnt_d   = '0;
        state_d = (words_q + 16'd1 == 16'(WORD_COUNT)) ? HOLD : COLLECT;
      end
      HOLD: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(RELEASE_DELAY - 1)) ? RUN : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drops any partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      part_q  <= '0;
      wdata_q <= '0;
      adr_q   <= '0;
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      wdata_q <= wdata_d;
      adr_q   <= adr_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready      = state_q == COLLECT;
  assign bus.Ext_MemWrite  = state_q == WRITE;
  assign bus.Ext_WriteData = wdata_q;
  assign bus.Ext_DataAdr   = adr_q;
  assign cpu_reset         = state_q != RUN;
  assign busy              = state_q inside {COLLECT, WRITE, HOLD};
  assign done              = state_q == RUN;
  assign words_loaded      = words_q;
endmodule

// File: doc/dmem_loader.md
# dmem_loader

Boot-time loader that drives the CPU unit's external data-memory write port (Ext_MemWrite, Ext_WriteData, Ext_DataAdr) and its reset input. It accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them to consecutive word addresses while the CPU is held in reset. After a programmable settle delay it releases the CPU to run.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word-aligned.
- WORD_COUNT, 64: words per load session; legal range 1..65535.
- RELEASE_DELAY, 4: cycles cpu_reset stays high after the last write; legal range 1..255.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load session.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle when in_valid && in_ready.
- Ext_MemWrite  out  1  external data-memory write strobe to the CPU unit.
- Ext_WriteData  out  32  assembled word.
- Ext_DataAdr  out  32  word byte-address.
- cpu_reset  out  1  drives the CPU unit's reset.
- busy  out  1  high whenever a session is in progress (not IDLE or RUN).
- done  out  1  high in RUN; cleared by start or reset.
- words_loaded  out  16  words written in the current or most recent session.

## Operation
- States: IDLE, COLLECT, WRITE, HOLD, RUN.
- Reset values: state IDLE, in_ready 0, Ext_MemWrite 0, Ext_WriteData 0, Ext_DataAdr 0, cpu_reset 1, busy 0, done 0, words_loaded 0, byte index 0.
- IDLE: cpu_reset 1. If start, go to COLLECT, clear words_loaded and byte index, set busy.
- COLLECT: in_ready 1. Each accepted byte k (0..3) goes to word bits [8k+7:8k]. When the 4th byte is accepted, go to WRITE.
- WRITE: lasts exactly one cycle. Ext_MemWrite 1, Ext_DataAdr = BASE_ADDR + 4*words_loaded (32-bit, wraps modulo 2^32), Ext_WriteData = the assembled word. words_loaded increments at the end of the cycle. Then:
  - if the new count == WORD_COUNT, go to HOLD;
  - otherwise return to COLLECT.
- HOLD: cpu_reset 1, in_ready 0. Counts RELEASE_DELAY cycles, then goes to RUN.
- RUN: cpu_reset 0, done 1, busy 0. A start here reasserts cpu_reset on the next cycle and enters COLLECT, starting a new session.
- cpu_reset is 1 in every state except RUN, so Ext_MemWrite is never high while cpu_reset is 0. The CPU unit only honours the external port while it is in reset.
- Ext_WriteData and Ext_DataAdr are registered and hold their last values outside WRITE.
- start is ignored in COLLECT, WRITE and HOLD.
- in_valid is ignored whenever in_ready is 0; no byte is consumed.
- Asserting reset in any state returns to IDLE with the reset values. A partial word is discarded and no write is issued.

## Timing
- Ext_MemWrite rises on the cycle after the edge that accepts the 4th byte.
- Minimum throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle. in_ready is 0 during WRITE.
- cpu_reset falls exactly RELEASE_DELAY+1 cycles after the last WRITE cycle: RELEASE_DELAY cycles in HOLD, then the first RUN cycle.
- start -> in_ready high: 1 cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then start, then stream bytes 0x11,0x22,0x33,0x44 with WORD_COUNT=1 and BASE_ADDR=0 -> one Ext_MemWrite pulse with Ext_DataAdr=0 and Ext_WriteData=0x44332211; cpu_reset falls RELEASE_DELAY+1 cycles later; done=1; words_loaded=1.
- WORD_COUNT=3, BASE_ADDR=0x100, in_valid held high -> writes at 0x100, 0x104, 0x108, spaced 5 cycles apart; exactly 3 pulses.
- Random in_valid gaps plus start pulses mid-session -> start ignored; data and addresses unchanged; no extra writes.
- Reset after 2 bytes of word 1 in a 2-word session -> no write; state IDLE; cpu_reset=1. Then start with a fresh stream -> first write at BASE_ADDR holding the new bytes.
- In RUN, pulse start -> cpu_reset=1 and done=0 the next cycle; words_loaded=0; a new session completes normally.
- Check on every cycle: Ext_MemWrite implies cpu_reset; in_ready=0 outside COLLECT.
